// File: rtl/grant_dec.sv
// Purpose: single-grant decoder; turns an encoded request index into a held one-hot grant until ACK (or optional timeout).
// Latency: one clock from accepted request (V=1 in IDLE) to Y; Y/TO are registered, BUSY decodes the state register.
// Backpressure: none queued; requests seen outside IDLE are dropped. Build with GRANT_DEC_TIMEOUT_EN for the forced-release timeout.
module grant_dec #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] A,
    input  logic       V,
    input  logic       ACK,
    output logic [3:0] Y,
    output logic       BUSY,
    output logic       TO
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Reject nonsensical timeout values at elaboration time.
    if (TIMEOUT < 2 || TIMEOUT > 15) begin : g_bad_timeout
        $error("grant_dec: TIMEOUT must lie in 2..15");
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [1:0] idx_nxt;
    logic [3:0] y_nxt;

`ifdef GRANT_DEC_TIMEOUT_EN
    // Counts completed GRANT cycles; the last one is TIMEOUT-1.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       to_nxt;
`endif

    // Next-state, captured index and next grant vector.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
`ifdef GRANT_DEC_TIMEOUT_EN
        cnt_nxt   = cnt;
        to_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (V) begin
                    state_nxt = GRANT;
                    idx_nxt   = A;
`ifdef GRANT_DEC_TIMEOUT_EN
                    cnt_nxt   = 4'd0;
`endif
                end
            end
            GRANT: begin
                // ACK has priority over a timeout expiring on the same edge.
                if (ACK) begin
                    state_nxt = RELEASE;
                end
`ifdef GRANT_DEC_TIMEOUT_EN
                else if (cnt == CNT_LAST) begin
                    state_nxt = RELEASE;
                    to_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
`endif
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        y_nxt = (state_nxt == GRANT) ? (4'b0001 << idx_nxt) : 4'b0000;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
            Y     <= 4'b0000;
`ifdef GRANT_DEC_TIMEOUT_EN
            cnt   <= 4'd0;
            TO    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            Y     <= y_nxt;
`ifdef GRANT_DEC_TIMEOUT_EN
            cnt   <= cnt_nxt;
            TO    <= to_nxt;
`endif
        end
    end

`ifndef GRANT_DEC_TIMEOUT_EN
    // Without the timeout option the grant is held until ACK and TO never fires.
    assign TO = 1'b0;
`endif

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_grant_dec.sv
// Purpose: self-checking bench for grant_dec: directed scenarios with literal expectations plus randomized traffic.
// Latency: a transaction-level model predicts Y/BUSY/TO one clock after each edge; checked every cycle.
// Backpressure: requests outside IDLE must vanish; the model simply never remembers them.
module tb_grant_dec;

    localparam int TIMEOUT = 8;
`ifdef GRANT_DEC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] A;
    logic       V;
    logic       ACK;
    logic [3:0] Y;
    logic       BUSY;
    logic       TO;

    int n_chk  = 0;
    int n_pass = 0;

    grant_dec #(.TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .V    (V),
        .ACK  (ACK),
        .Y    (Y),
        .BUSY (BUSY),
        .TO   (TO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference model: who holds the grant, for how many cycles, and whether
    // the current release cycle was caused by the timeout.
    int holder  = -1;  // granted line, -1 when nobody holds a grant
    int held    = 0;   // grant cycles completed so far
    bit rel     = 1'b0;
    bit rel_to  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            holder = -1; held = 0; rel = 1'b0; rel_to = 1'b0;
        end else if (holder >= 0) begin
            held = held + 1;
            if (ACK) begin
                holder = -1; rel = 1'b1; rel_to = 1'b0;
            end else if (TO_EN && held == TIMEOUT) begin
                holder = -1; rel = 1'b1; rel_to = 1'b1;
            end
        end else if (rel) begin
            rel = 1'b0; rel_to = 1'b0;
        end else if (V) begin
            holder = int'(A); held = 0;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            check("y_model",    Y,    (holder >= 0) ? (32'd1 << holder) : 32'd0);
            check("busy_model", BUSY, {31'd0, (holder >= 0) || rel});
            check("to_model",   TO,   {31'd0, rel && rel_to});
            check("y_onehot0",  {31'd0, $countones(Y) <= 1}, 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [3:0] onehot_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        rst = 1'b1; V = 1'b0; A = 2'd0; ACK = 1'b0;
        step();
        check("rst_y", Y, 0); check("rst_busy", BUSY, 0); check("rst_to", TO, 0);
        rst = 1'b0;
        step();

        // Basic grant on line 2, ACK after three grant cycles.
        V = 1'b1; A = 2'd2; step();
        V = 1'b0; check("basic_y1", Y, 4'b0100); check("basic_busy", BUSY, 1);
        step(); check("basic_y2", Y, 4'b0100);
        step(); check("basic_y3", Y, 4'b0100); ACK = 1'b1;
        step(); ACK = 1'b0; check("basic_rel_y", Y, 0); check("basic_rel_busy", BUSY, 1);
        step(); check("basic_idle_busy", BUSY, 0); check("basic_idle_y", Y, 0);

        // Sweep every index.
        for (int i = 0; i < 4; i++) begin
            V = 1'b1; A = 2'(i); step();
            V = 1'b0; check("sweep_y", Y, onehot_tbl[i]); ACK = 1'b1;
            step(); ACK = 1'b0; check("sweep_rel_y", Y, 0);
            step();
        end

`ifdef GRANT_DEC_TIMEOUT_EN
        // Timeout: line 3 held for TIMEOUT cycles, then one TO cycle.
        V = 1'b1; A = 2'd3; step();
        V = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            check("tmo_y_held", Y, 4'b1000); check("tmo_to_low", TO, 0); step();
        end
        check("tmo_rel_y", Y, 0); check("tmo_pulse", TO, 1); check("tmo_rel_busy", BUSY, 1);
        step(); check("tmo_after_to", TO, 0); check("tmo_after_busy", BUSY, 0);

        // ACK on the very last counted cycle beats the timeout.
        V = 1'b1; A = 2'd1; step();
        V = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        check("tie_y", Y, 4'b0010); ACK = 1'b1;
        step(); ACK = 1'b0; check("tie_to", TO, 0); check("tie_rel_y", Y, 0); check("tie_rel_busy", BUSY, 1);
        step(); check("tie_idle_busy", BUSY, 0); check("tie_idle_to", TO, 0);
`else
        // No timeout build: grant held for 20 cycles without ACK.
        V = 1'b1; A = 2'd3; step();
        V = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("hold_y", Y, 4'b1000); check("hold_to", TO, 0); step();
        end
        ACK = 1'b1; step(); ACK = 1'b0; check("hold_rel_y", Y, 0);
        step();
`endif

        // Requests during GRANT and RELEASE are dropped.
        V = 1'b1; A = 2'd2; step();
        A = 2'd1; check("drop_y1", Y, 4'b0100);
        step(); check("drop_y2", Y, 4'b0100); ACK = 1'b1;
        step(); ACK = 1'b0; check("drop_rel_y", Y, 0); check("drop_rel_busy", BUSY, 1);
        step(); V = 1'b0; check("drop_idle_y", Y, 0); check("drop_idle_busy", BUSY, 0);
        step(); check("drop_not_served", Y, 0);

        // Asynchronous reset pulse mid-GRANT, between edges.
        V = 1'b1; A = 2'd0; step();
        V = 1'b0; step();
        check("arst_pre_y", Y, 4'b0001);
        #2 rst = 1'b1;
        #1 check("arst_y", Y, 0); check("arst_busy", BUSY, 0); check("arst_to", TO, 0);
        rst = 1'b0;
        step(); check("arst_after_to", TO, 0); check("arst_after_y", Y, 0);
        V = 1'b1; A = 2'd3; step();
        V = 1'b0; check("arst_accept_y", Y, 4'b1000); ACK = 1'b1;
        step(); ACK = 1'b0;
        step();

        // Randomized traffic, occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                #1 check("rnd_arst_y", Y, 0); check("rnd_arst_busy", BUSY, 0); check("rnd_arst_to", TO, 0);
                rst = 1'b0;
            end
            V   = ($urandom_range(0, 9) < 6);
            A   = 2'($urandom_range(0, 3));
            ACK = ($urandom_range(0, 5) == 0);
            step();
        end
        V = 1'b0; ACK = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/grant_dec.md
GRANT_DEC -- requirements
Module: grant_dec

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8, meaning the number of GRANT cycles without ACK before forced release; legal range 2..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 The block SHALL have port A, input, 2, the encoded request index (priority-encoder output format, 2'b11 = highest line).
REQ-005 The block SHALL have port V, input, 1, meaning A is valid this cycle.
REQ-006 The block SHALL have port ACK, input, 1, the target's acknowledge of the current grant.
REQ-007 The block SHALL have port Y, output, 4, the registered one-hot grant, Y[A] asserted.
REQ-008 The block SHALL have port BUSY, output, 1, high in GRANT and RELEASE.
REQ-009 The block SHALL have port TO, output, 1, a one-cycle timeout pulse.

Function
REQ-010 The FSM SHALL have three states: IDLE, GRANT and RELEASE.
REQ-011 In IDLE with V=1 at a clock edge, the block SHALL capture A and enter GRANT, with Y = 4'b0001 << A on the following cycle (latency 1 clock).
REQ-012 In IDLE with V=0, the block SHALL remain in IDLE with Y=4'b0000 and BUSY=0.
REQ-013 In GRANT, Y SHALL stay constant at the captured one-hot value and BUSY SHALL be 1.
REQ-014 V and A SHALL be ignored outside IDLE; requests arriving then are dropped, not queued.
REQ-015 ACK SHALL be ignored in IDLE and RELEASE.
REQ-016 In GRANT with ACK=1 at an edge, the block SHALL enter RELEASE with Y=0 on the next cycle.
REQ-017 A 4-bit cycle counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-018 If the counter reaches TIMEOUT-1 with ACK=0, the block SHALL enter RELEASE and assert TO for exactly that one following cycle.
REQ-019 If ACK=1 in the same cycle the counter reaches TIMEOUT-1, ACK SHALL win and TO SHALL stay 0.
REQ-020 RELEASE SHALL last exactly one cycle with Y=0 and BUSY=1, then return to IDLE unconditionally.
REQ-021 A V=1 in the RELEASE cycle SHALL be dropped; the earliest accepted request follows in IDLE.
REQ-022 Y SHALL never have more than one bit set, and SHALL never be nonzero outside GRANT.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, force state IDLE, Y=4'b0000, BUSY=0, TO=0, counter=0 and captured index=0.
REQ-024 Reset asserted mid-GRANT SHALL drop the grant with no TO pulse.
REQ-025 After rst deasserts, the first edge with V=1 SHALL be accepted normally.

Configuration
REQ-026 The timeout SHALL be compiled in only when macro GRANT_DEC_TIMEOUT_EN is defined.
REQ-027 With GRANT_DEC_TIMEOUT_EN defined, REQ-017..REQ-019 SHALL apply.
REQ-028 Without GRANT_DEC_TIMEOUT_EN, GRANT SHALL be held until ACK indefinitely, TO SHALL be tied to 0, and no counter SHALL be built.
REQ-029 The port list SHALL be identical in both builds.

Verification
REQ-030 The bench SHALL cover the basic grant: after reset, A=2'b10 with V=1 for one edge, then ACK=1 three cycles later -> Y=4'b0100 one cycle after V, held 3 cycles, then Y=0 for one RELEASE cycle, BUSY=0 afterwards.
REQ-031 The bench SHALL cover all indices: sweep A=0..3, each followed by ACK -> Y = 0001, 0010, 0100, 1000 respectively, never multi-hot.
REQ-032 The bench SHALL cover timeout: TIMEOUT=8, A=2'b11 and V=1, ACK never asserted -> Y=4'b1000 for 8 cycles, then TO=1 for one cycle with Y=0, then IDLE.
REQ-033 The bench SHALL cover ACK winning the tie: ACK=1 on the exact cycle the counter hits 7 -> TO stays 0 and release proceeds normally.
REQ-034 The bench SHALL cover dropped requests: V=1 with A=2'b01 while Y=4'b0100 and during RELEASE -> Y unaffected and request not served later.
REQ-035 The bench SHALL cover async reset: rst pulsed mid-GRANT between clock edges -> Y=0, BUSY=0 immediately, TO never pulses; and with GRANT_DEC_TIMEOUT_EN undefined, 20 cycles without ACK -> Y held, TO=0.
